hazard_flush_ctrl: RTL and testbench

Central pipeline hazard controller: the producer side of the clrHDU/clrBU clear interface consumed by every execute-stage control-signal register (ALUOp, RegWrite, MemToReg, ...). It detects load-use hazards and taken branches and drives stall and clear signals to the F/D/E/M pipeline registers. It also freezes the pipeline while data memory is busy and keeps saturating stall/flush performance counters. It sits beside the decode stage and samples decode-stage and execute-stage fields.

---
 rtl/hazard_flush_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_flush_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl
// Central pipeline hazard controller. Detects load-use hazards between the
// decode and execute stages and taken branches resolved in execute, then
// drives per-stage hold enables and the clrHDU/clrBU clear strobes. A busy
// data memory freezes the whole pipeline and defers any pending action.
// Saturating counters track stall cycles and flush cycles.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   rs1_de, rs2_de             decode-stage source registers
//   use_rs1_de, use_rs2_de     decode instruction actually reads rs1 / rs2
//   rd_ex                      execute-stage destination register
//   memtoreg_ex, regwrite_ex   execute instruction is a load / writes a reg
//   branch_taken_ex            branch resolved taken in execute
//   mem_busy                   data memory not ready, hold everything
//   stall_f/d/e/m              hold enables for the F/D/E/M registers
//   clrHDU                     load-use bubble into E-stage controls
//   clrBU                      branch flush of D and E stages
//   stall_cnt, flush_cnt       saturating stall / flush cycle counters
//
// Operating mode, resolved each cycle (highest priority first):
//   mode   | meaning
//   busy   | mem_busy: all stages held, timers frozen, no clears
//   branch | taken branch or branch tail running: clrBU, load-use dropped
//   lu     | load-use hit or stall tail running: hold F/D, bubble into E
//   idle   | nothing asserted

module hazard_flush_ctrl #(
   parameter int REG_W     = 4,
   parameter int LU_CYCLES = 1,
   parameter int BR_EXTRA  = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] rs1_de,
   input  logic [REG_W-1:0] rs2_de,
   input  logic             use_rs1_de,
   input  logic             use_rs2_de,
   input  logic [REG_W-1:0] rd_ex,
   input  logic             memtoreg_ex,
   input  logic             regwrite_ex,
   input  logic             branch_taken_ex,
   input  logic             mem_busy,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             clrHDU,
   output logic             clrBU,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Remaining-cycle timers; the hit cycle itself is not counted, hence -1.
   localparam logic [2:0] LU_RELOAD = 3'(LU_CYCLES - 1);
   localparam logic [2:0] BR_RELOAD = 3'(BR_EXTRA);

   logic [2:0]       r_lu_cnt;
   logic [2:0]       r_br_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_lu_hit;
   logic w_br_act;
   logic w_lu_act;
   logic w_busy_mode;
   logic w_br_mode;
   logic w_lu_mode;

   assign w_lu_hit = memtoreg_ex & regwrite_ex &
                     ((use_rs1_de & (rs1_de == rd_ex)) |
                      (use_rs2_de & (rs2_de == rd_ex)));

   assign w_br_act = branch_taken_ex | (r_br_cnt != 3'd0);
   assign w_lu_act = w_lu_hit | (r_lu_cnt != 3'd0);

   // Gating with rst_n keeps the combinational paths quiet during reset too.
   assign w_busy_mode = rst_n & mem_busy;
   assign w_br_mode   = rst_n & ~mem_busy & w_br_act;
   assign w_lu_mode   = rst_n & ~mem_busy & ~w_br_act & w_lu_act;

   assign stall_f   = w_busy_mode | w_lu_mode;
   assign stall_d   = w_busy_mode | w_lu_mode;
   assign stall_e   = w_busy_mode;
   assign stall_m   = w_busy_mode;
   assign clrHDU    = w_lu_mode;
   assign clrBU     = w_br_mode;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

   // Timers. While busy nothing moves; EX is frozen so the triggering inputs
   // are still present once the memory frees up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lu_cnt <= 3'd0;
         r_br_cnt <= 3'd0;
      end else if (w_br_mode) begin
         // Flush kills the dependent instruction, so any load-use tail goes.
         r_lu_cnt <= 3'd0;
         if (branch_taken_ex)
            r_br_cnt <= BR_RELOAD;
         else
            r_br_cnt <= r_br_cnt - 3'd1;
      end else if (w_lu_mode) begin
         if (w_lu_hit && (r_lu_cnt == 3'd0))
            r_lu_cnt <= LU_RELOAD;
         else
            r_lu_cnt <= r_lu_cnt - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall_f && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (clrBU && (r_flush_cnt != {CNT_W{1'b1}}))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
module tb_hazard_flush_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] rs1_de, rs2_de, rd_ex;
   logic       use_rs1_de, use_rs2_de, memtoreg_ex, regwrite_ex;
   logic       branch_taken_ex, mem_busy;

   logic        a_sf, a_sd, a_se, a_sm, a_hdu, a_bu;
   logic [15:0] a_sc, a_fc;
   logic        b_sf, b_sd, b_se, b_sm, b_hdu, b_bu;
   logic [3:0]  b_sc, b_fc;

   always #5 clk = ~clk;

   // Instance A: single-cycle load-use, wide counters.
   hazard_flush_ctrl #(.REG_W(4), .LU_CYCLES(1), .BR_EXTRA(1), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .rs1_de(rs1_de), .rs2_de(rs2_de),
      .use_rs1_de(use_rs1_de), .use_rs2_de(use_rs2_de), .rd_ex(rd_ex),
      .memtoreg_ex(memtoreg_ex), .regwrite_ex(regwrite_ex),
      .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
      .stall_f(a_sf), .stall_d(a_sd), .stall_e(a_se), .stall_m(a_sm),
      .clrHDU(a_hdu), .clrBU(a_bu), .stall_cnt(a_sc), .flush_cnt(a_fc));

   // Instance B: three-cycle load-use, narrow counters so saturation is reachable.
   hazard_flush_ctrl #(.REG_W(4), .LU_CYCLES(3), .BR_EXTRA(1), .CNT_W(4)) u_b (
      .clk(clk), .rst_n(rst_n), .rs1_de(rs1_de), .rs2_de(rs2_de),
      .use_rs1_de(use_rs1_de), .use_rs2_de(use_rs2_de), .rd_ex(rd_ex),
      .memtoreg_ex(memtoreg_ex), .regwrite_ex(regwrite_ex),
      .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
      .stall_f(b_sf), .stall_d(b_sd), .stall_e(b_se), .stall_m(b_sm),
      .clrHDU(b_hdu), .clrBU(b_bu), .stall_cnt(b_sc), .flush_cnt(b_fc));

   // Reference model: timestamps over non-busy cycles.
   int lu_p [2] = '{1, 3};
   int br_p [2] = '{1, 1};
   int cmax [2] = '{65535, 15};
   int t [2];
   int br_end [2];
   int lu_end [2];
   int sc [2];
   int fc [2];

   int checks = 0;
   int errors = 0;

   function automatic logic [5:0] dut_ctl(int k);
      if (k == 0) return {a_sf, a_sd, a_se, a_sm, a_hdu, a_bu};
      return {b_sf, b_sd, b_se, b_sm, b_hdu, b_bu};
   endfunction

   function automatic int dut_sc(int k);
      if (k == 0) return int'(a_sc);
      return int'(b_sc);
   endfunction

   function automatic int dut_fc(int k);
      if (k == 0) return int'(a_fc);
      return int'(b_fc);
   endfunction

   function automatic logic lu_hit_f();
      return memtoreg_ex && regwrite_ex &&
             ((use_rs1_de && rs1_de == rd_ex) || (use_rs2_de && rs2_de == rd_ex));
   endfunction

   // {stall_f, stall_d, stall_e, stall_m, clrHDU, clrBU}
   function automatic logic [5:0] exp_ctl(int k);
      if (!rst_n) return 6'b000000;
      if (mem_busy) return 6'b111100;
      if (branch_taken_ex || t[k] <= br_end[k]) return 6'b000001;
      if (lu_hit_f() || t[k] <= lu_end[k]) return 6'b110010;
      return 6'b000000;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         t[k] = 0; br_end[k] = -1; lu_end[k] = -1; sc[k] = 0; fc[k] = 0;
      end
   endtask

   task automatic model_edge();
      logic [5:0] e;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         e = exp_ctl(k);
         if (e[5] && sc[k] < cmax[k]) sc[k]++;
         if (e[0] && fc[k] < cmax[k]) fc[k]++;
         if (!mem_busy) begin
            if (branch_taken_ex || t[k] <= br_end[k]) begin
               if (branch_taken_ex) br_end[k] = t[k] + br_p[k];
               lu_end[k] = -1;
            end else if (lu_hit_f() && !(t[k] <= lu_end[k])) begin
               lu_end[k] = t[k] + lu_p[k] - 1;
            end
            t[k]++;
         end
      end
   endtask

   task automatic check(string name, int k, int got, int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst=%0d got=%0h exp=%0h at %0t", name, k, got, exp, $time);
      end
   endtask

   // Compare every output of both instances against the model (at negedge).
   task automatic cyc();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("ctl", k, int'(dut_ctl(k)), int'(exp_ctl(k)));
         check("stall_cnt", k, dut_sc(k), sc[k]);
         check("flush_cnt", k, dut_fc(k), fc[k]);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      rs1_de = 4'd0; rs2_de = 4'd0; rd_ex = 4'd0;
      use_rs1_de = 1'b0; use_rs2_de = 1'b0;
      memtoreg_ex = 1'b0; regwrite_ex = 1'b0;
      branch_taken_ex = 1'b0; mem_busy = 1'b0;
   endtask

   task automatic hazard();
      memtoreg_ex = 1'b1; regwrite_ex = 1'b1; rd_ex = 4'd5;
      rs2_de = 4'd5; use_rs2_de = 1'b1; rs1_de = 4'd1; use_rs1_de = 1'b0;
   endtask

   // Mid-cycle reset: outputs must drop immediately, then a clean cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_ctl", k, int'(dut_ctl(k)), 0);
         check("rst_stall_cnt", k, dut_sc(k), 0);
         check("rst_flush_cnt", k, dut_fc(k), 0);
      end
      model_reset();
      idle();
      cyc();
      adv();
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      model_reset();
      cyc();
      for (int k = 0; k < 2; k++) check("init_ctl", k, int'(dut_ctl(k)), 0);
      adv();
      rst_n = 1'b1;

      // Load-use: A stalls one cycle, B three.
      do_reset();
      hazard();
      cyc();
      check("lu_a_first", 0, int'(dut_ctl(0)), 6'b110010);
      check("lu_b_first", 1, int'(dut_ctl(1)), 6'b110010);
      adv();
      idle();
      cyc();
      check("lu_a_done", 0, int'(dut_ctl(0)), 0);
      check("lu_b_2", 1, int'(dut_ctl(1)), 6'b110010);
      adv();
      cyc();
      check("lu_b_3", 1, int'(dut_ctl(1)), 6'b110010);
      adv();
      cyc();
      check("lu_b_done", 1, int'(dut_ctl(1)), 0);
      check("lu_a_cnt", 0, dut_sc(0), 1);
      check("lu_b_cnt", 1, dut_sc(1), 3);
      adv();

      // Single branch: clrBU for two cycles.
      do_reset();
      branch_taken_ex = 1'b1;
      cyc();
      check("br_1", 0, int'(dut_ctl(0)), 6'b000001);
      adv();
      branch_taken_ex = 1'b0;
      cyc();
      check("br_2", 0, int'(dut_ctl(0)), 6'b000001);
      adv();
      cyc();
      check("br_done", 0, int'(dut_ctl(0)), 0);
      check("br_fcnt", 0, dut_fc(0), 2);
      adv();

      // Second taken branch in the tail cycle extends to three.
      do_reset();
      branch_taken_ex = 1'b1;
      cyc(); adv();
      cyc(); adv();
      branch_taken_ex = 1'b0;
      cyc();
      check("br2_3", 0, int'(dut_ctl(0)), 6'b000001);
      adv();
      cyc();
      check("br2_done", 0, int'(dut_ctl(0)), 0);
      check("br2_fcnt", 0, dut_fc(0), 3);
      adv();

      // Load-use coinciding with branch: branch wins, no stall tail.
      do_reset();
      hazard();
      branch_taken_ex = 1'b1;
      cyc();
      check("mix_1", 1, int'(dut_ctl(1)), 6'b000001);
      adv();
      idle();
      cyc();
      check("mix_2", 1, int'(dut_ctl(1)), 6'b000001);
      adv();
      cyc();
      check("mix_done", 1, int'(dut_ctl(1)), 0);
      adv();

      // Memory busy with branch held: deferred flush.
      do_reset();
      branch_taken_ex = 1'b1;
      mem_busy = 1'b1;
      repeat (4) begin
         cyc();
         check("busy_ctl", 0, int'(dut_ctl(0)), 6'b111100);
         adv();
      end
      mem_busy = 1'b0;
      cyc();
      check("busy_release", 0, int'(dut_ctl(0)), 6'b000001);
      check("busy_scnt", 0, dut_sc(0), 4);
      adv();
      branch_taken_ex = 1'b0;
      cyc(); adv();
      cyc(); adv();

      // Saturation of the narrow counter.
      do_reset();
      mem_busy = 1'b1;
      repeat (20) begin cyc(); adv(); end
      cyc();
      check("sat_b", 1, dut_sc(1), 15);
      check("sat_a", 0, dut_sc(0), 20);
      adv();
      mem_busy = 1'b0;

      // Reset mid-stall and mid-flush, then a clean cycle.
      do_reset();
      hazard();
      cyc(); adv();
      idle();
      cyc(); adv();
      do_reset();
      cyc();
      check("post_rst_lu", 1, int'(dut_ctl(1)), 0);
      adv();
      branch_taken_ex = 1'b1;
      cyc(); adv();
      do_reset();
      cyc();
      check("post_rst_br", 0, int'(dut_ctl(0)), 0);
      adv();

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            rs1_de          = 4'($urandom_range(0, 3));
            rs2_de          = 4'($urandom_range(0, 3));
            rd_ex           = 4'($urandom_range(0, 3));
            use_rs1_de      = 1'($urandom_range(0, 1));
            use_rs2_de      = 1'($urandom_range(0, 1));
            memtoreg_ex     = ($urandom_range(0, 2) != 0);
            regwrite_ex     = ($urandom_range(0, 3) != 0);
            branch_taken_ex = ($urandom_range(0, 9) == 0);
            mem_busy        = ($urandom_range(0, 6) == 0);
         end
         cyc();
         adv();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
